// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver: segment encodings and idle levels.
package ssd_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/ssd_scan_driver_if.sv
// Value/control inputs and display outputs of the scan driver.
interface ssd_scan_driver_if;
  logic [31:0] value_in;
  logic        load;
  logic        half_sel;
  logic        blank_lz;
  logic [6:0]  c;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output value_in, load, half_sel, blank_lz,
    input  c, an, frame_done
  );

  modport slave (
    input  value_in, load, half_sel, blank_lz,
    output c, an, frame_done
  );
endinterface

// File: rtl/ssd_scan_driver_hex_to_ssd.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_ssd
  import ssd_scan_driver_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed 4-digit hex display driver; new values commit only at scan-frame boundaries.
module ssd_scan_driver
  import ssd_scan_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  ssd_scan_driver_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      staging_q, staging_d;
  logic [31:0]      shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             half_q, half_d;
  logic [6:0]       c_q, c_d;
  logic [3:0]       an_q, an_d;

  logic             tc;
  logic             boundary;
  logic [15:0]      sel_half;
  logic [3:0]       nib;
  logic [6:0]       seg;
  logic             blank;

  assign tc       = (div_q == DIV_W'(REFRESH_DIV - 1));
  assign boundary = tc && (idx_q == 2'd3);

  always_comb begin
    div_d     = div_q;
    idx_d     = idx_q;
    staging_d = staging_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    half_d    = half_q;

    if (tc) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (bus.load) begin
      staging_d = bus.value_in;
      pending_d = 1'b1;
    end

    // A load landing on the boundary bypasses staging so it is never left pending
    if (boundary) begin
      half_d    = bus.half_sel;
      pending_d = 1'b0;
      if (bus.load) begin
        shadow_d = bus.value_in;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
    end
  end

  assign sel_half = half_q ? shadow_q[31:16] : shadow_q[15:0];
  assign nib      = sel_half[{idx_q, 2'b00} +: 4];

  always_comb begin
    blank = 1'b0;
    if (bus.blank_lz) begin
      case (idx_q)
        2'd1:    blank = (sel_half[15:4]  == 12'h000);
        2'd2:    blank = (sel_half[15:8]  == 8'h00);
        2'd3:    blank = (sel_half[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
  end

  hex_to_ssd u_hex_to_ssd (
    .nib_i (nib),
    .seg_o (seg)
  );

  assign c_d  = blank ? SEG_OFF : seg;
  assign an_d = ~(4'b0001 << idx_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= 2'd0;
      staging_q <= 32'h0;
      shadow_q  <= 32'h0;
      pending_q <= 1'b0;
      half_q    <= 1'b0;
      c_q       <= SEG_OFF;
      an_q      <= AN_OFF;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      half_q    <= half_d;
      c_q       <= c_d;
      an_q      <= an_d;
    end
  end

  assign bus.c          = c_q;
  assign bus.an         = an_q;
  assign bus.frame_done = boundary && !reset;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: directed vector table, corner sequences, random run vs. frame model.
module tb_ssd_scan_driver;

  localparam int RD    = 4;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: position in the scan comes from the cycle count since reset
  int          cyc;
  logic [31:0] m_shadow;
  bit          m_half;
  logic [31:0] m_q [$];
  logic [6:0]  exp_c;
  logic [3:0]  exp_an;
  bit          exp_valid = 0;
  int          m_idx;
  int          m_sel;
  logic [3:0]  m_onehot;

  always @(posedge clk) begin
    if (reset) begin
      exp_c     = 7'h7F;
      exp_an    = 4'hF;
      cyc       = 0;
      m_q.delete();
      m_shadow  = 32'h0;
      m_half    = 0;
      exp_valid = 1;
    end else begin
      m_idx = (cyc / RD) % 4;
      m_sel = m_half ? int'(m_shadow[31:16]) : int'(m_shadow[15:0]);
      if (bus.blank_lz && m_idx > 0 && (m_sel >> (4 * m_idx)) == 0)
        exp_c = 7'h7F;
      else
        exp_c = SEG[(m_sel >> (4 * m_idx)) & 15];
      m_onehot = 4'b0001 << m_idx;
      exp_an   = ~m_onehot;
      if (bus.load) m_q.push_back(bus.value_in);
      if ((cyc % FRAME) == FRAME - 1) begin
        if (m_q.size() > 0) m_shadow = m_q[$];
        m_q.delete();
        m_half = bus.half_sel;
      end
      cyc++;
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (exp_valid) begin
      chk("sb_c", 32'(bus.c), 32'(exp_c));
      chk("sb_an", 32'(bus.an), 32'(exp_an));
      chk("sb_frame_done", 32'(bus.frame_done),
          32'(!reset && (cyc % FRAME) == FRAME - 1));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd();
    bit seen = 0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      step();
      if (bus.frame_done) seen = 1;
    end
    if (!seen) chk("frame_done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [31:0]     val;
    bit              half;
    bit              blz;
    bit              toggle;
    logic [3:0][6:0] exp_c;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input int n);
    logic [3:0] want_an;
    bus.value_in = v.val;
    bus.half_sel = v.half;
    bus.blank_lz = v.blz;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    wait_fd();
    for (int j = 1; j <= FRAME; j++) begin
      step();
      if (v.toggle && j == 1) bus.half_sel = ~bus.half_sel;
      if (j % RD == 2) begin
        want_an = ~(4'b0001 << ((j - 2) / RD));
        chk($sformatf("vec%0d_c_digit%0d", n, (j - 2) / RD), 32'(bus.c),
            32'(v.exp_c[(j - 2) / RD]));
        chk($sformatf("vec%0d_an_digit%0d", n, (j - 2) / RD), 32'(bus.an), 32'(want_an));
      end
    end
  endtask

  int cnt;
  int ones;
  int nonzero;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'h0000_1234, 1'b0, 1'b0, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{32'hABCD_0000, 1'b1, 1'b0, 1'b1,
                {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
    vecs[2] = '{32'h0000_0050, 1'b0, 1'b1, 1'b0,
                {7'h7F, 7'h7F, 7'b0010010, 7'b1000000}};
    vecs[3] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0,
                {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
    vecs[4] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0,
                {7'b0000000, 7'b1000000, 7'b1000000, 7'b1000000}};

    bus.value_in = 32'h0;
    bus.load     = 1'b0;
    bus.half_sel = 1'b0;
    bus.blank_lz = 1'b0;

    // Reset held three cycles, then first digit and frame cadence
    repeat (3) step();
    chk("reset_c", 32'(bus.c), 32'h7F);
    chk("reset_an", 32'(bus.an), 32'hF);
    chk("reset_frame_done", 32'(bus.frame_done), 0);
    reset = 1'b0;
    step();
    chk("first_an", 32'(bus.an), 32'b1110);
    chk("first_c", 32'(bus.c), 32'b1000000);
    cnt = 1;
    while (!bus.frame_done && cnt < 100) begin
      step();
      cnt++;
    end
    chk("first_frame_len", cnt, FRAME - 1);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!bus.frame_done && cnt < 100);
    chk("frame_period", cnt, FRAME);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Two loads in one frame: only the last reaches the display
    bus.half_sel = 1'b0;
    bus.blank_lz = 1'b0;
    wait_fd();
    step();
    ones = 0;
    bus.value_in = 32'h0000_1111;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    if (bus.c == SEG[1]) ones++;
    step();
    if (bus.c == SEG[1]) ones++;
    bus.value_in = 32'h0000_2222;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    if (bus.c == SEG[1]) ones++;
    wait_fd();
    for (int j = 1; j <= FRAME; j++) begin
      step();
      if (bus.c == SEG[1]) ones++;
      if (j % RD == 2) chk("last_load_wins_c", 32'(bus.c), 32'(SEG[2]));
    end
    chk("no_1111_seen", ones, 0);

    // Load on the frame_done cycle shows up in the very next digit-0 slot
    wait_fd();
    bus.value_in = 32'h0000_3333;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk("boundary_load_old_digit", 32'(bus.c), 32'(SEG[2]));
    step();
    chk("boundary_load_c", 32'(bus.c), 32'(SEG[3]));
    chk("boundary_load_an", 32'(bus.an), 32'b1110);

    // Pending load discarded by reset mid-frame
    wait_fd();
    step();
    bus.value_in = 32'h0000_9999;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("midreset_c", 32'(bus.c), 32'h7F);
    chk("midreset_an", 32'(bus.an), 32'hF);
    step();
    chk("midreset_c2", 32'(bus.c), 32'h7F);
    chk("midreset_frame_done", 32'(bus.frame_done), 0);
    reset = 1'b0;
    nonzero = 0;
    for (int j = 0; j < 3 * FRAME; j++) begin
      step();
      if (bus.c != SEG[0]) nonzero++;
    end
    chk("after_reset_all_zero_digits", nonzero, 0);

    // Randomized run against the model
    for (int i = 0; i < 1200; i++) begin
      step();
      reset = ($urandom_range(0, 249) == 0);
      bus.load = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 4))
        0: bus.value_in = $urandom();
        1: bus.value_in = $urandom() & 32'h0000_FFFF;
        2: bus.value_in = $urandom() & 32'h00F0_000F;
        3: bus.value_in = $urandom() & 32'h0000_00FF;
        default: bus.value_in = 32'h0;
      endcase
      if ($urandom_range(0, 19) == 0) bus.half_sel = ~bus.half_sel;
      if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
    end
    reset = 1'b0;
    bus.load = 1'b0;
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
